// File: rtl/blram_ctrl.sv
// blram_ctrl: request/response front-end for a 32-bit block RAM with a
// 1-cycle registered read port and synchronous write port. One transaction
// is outstanding at a time. Byte-enabled partial writes are merged by a
// read-modify-write sequence when BLRAM_CTRL_RMW_EN is defined; otherwise
// any nonzero byte enable writes the full word. be = 0 is always a no-op.
module blram_ctrl #(
  parameter int ADDR_LEN = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [3:0]          i_req_be,
  input  logic [ADDR_LEN-1:0] i_req_addr,
  input  logic [31:0]         i_req_wdata,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [31:0]         o_rsp_rdata,
  output logic                o_ram_we,
  output logic [ADDR_LEN-1:0] o_ram_addr,
  output logic [31:0]         o_ram_data_in,
  input  logic [31:0]         i_ram_data_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_WAIT   = 3'd1,
    RD_CAPT   = 3'd2,
    WR_COMMIT = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t r_state;
  logic   w_accept;
  logic   w_full;

  assign o_req_ready = (r_state == IDLE);
  assign w_accept    = i_req_valid & o_req_ready;

`ifdef BLRAM_CTRL_RMW_EN
  // Only an all-ones enable skips the read phase.
  assign w_full = (i_req_be == 4'hF);

  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;

  // Byte-wise merge of new write data over the word currently in RAM.
  function automatic logic [31:0] merge_bytes(input logic [31:0] wdata,
                                              input logic [31:0] old,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  // Hold the request fields needed later by the merge step; sampled only on accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= i_req_we;
      r_be    <= i_req_be;
      r_wdata <= i_req_wdata;
    end
  end
`else
  // Without merge support any nonzero enable writes the whole word.
  assign w_full = (i_req_be != 4'h0);
`endif

  // Transaction FSM with registered RAM-side and response-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_ram_we      <= 1'b0;
      o_ram_addr    <= '0;
      o_ram_data_in <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            o_ram_addr <= i_req_addr;
            if (!i_req_we) begin
              r_state <= RD_WAIT;
            end else if (i_req_be == 4'h0) begin
              // No-op write: nothing touches the RAM, response data is zero.
              o_rsp_rdata <= '0;
              r_state     <= RESP;
            end else if (w_full) begin
              o_ram_we      <= 1'b1;
              o_ram_data_in <= i_req_wdata;
              o_rsp_rdata   <= i_req_wdata;
              r_state       <= WR_COMMIT;
            end else begin
              // Partial write: fetch the old word first.
              r_state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // RAM samples o_ram_addr on this edge; data is visible next cycle.
          r_state <= RD_CAPT;
        end
        RD_CAPT: begin
`ifdef BLRAM_CTRL_RMW_EN
          if (r_we) begin
            o_ram_we      <= 1'b1;
            o_ram_data_in <= merge_bytes(r_wdata, i_ram_data_out, r_be);
            o_rsp_rdata   <= merge_bytes(r_wdata, i_ram_data_out, r_be);
            r_state       <= WR_COMMIT;
          end else begin
            o_rsp_rdata <= i_ram_data_out;
            o_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
`else
          o_rsp_rdata <= i_ram_data_out;
          o_rsp_valid <= 1'b1;
          r_state     <= RESP;
`endif
        end
        WR_COMMIT: begin
          // The RAM performs the write on this edge; read data here is never used.
          o_ram_we    <= 1'b0;
          o_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          // A no-op arrives with valid low and raises it one edge later,
          // giving it the same one-edge latency as a full write.
          if (!o_rsp_valid) begin
            o_rsp_valid <= 1'b1;
          end else if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          o_ram_we    <= 1'b0;
          o_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule
